rst_seq_multi: RTL and testbench

Parametrised multi-domain reset sequencer. It runs on the already-generated system clock and takes the raw PLL lock as input. It produces NUM_DOM staged reset outputs, released in order 0..NUM_DOM-1 after lock is filtered as stable. It adds behaviour the basic generator lacks: lock-glitch filtering, staged release, a sticky lock-loss flag and a soft-reset handshake.

---
 rtl/rst_seq_pkg.sv | 7 +
 rtl/rst_seq_multi_sync.sv | 14 +
 rtl/rst_seq_multi.sv | 126 ++++++++++++
 tb/tb_rst_seq_multi.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg: FSM state encoding and counter-width helper shared by the reset sequencer.
package rst_seq_pkg;
   typedef enum logic [2:0] {S_WAIT_LOCK, S_HOLD, S_RELEASE, S_RUN, S_SOFT} state_t;
   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction
endpackage

// File: rtl/rst_seq_multi_sync.sv
// sync_bit: STAGES-flop single-bit synchroniser, synchronous active-high reset to 0.
//   i_clk destination clock, i_rst sync reset, i_d asynchronous input, o_q synchronised output.
module sync_bit #(
   parameter int STAGES = 3
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_q
);
   logic [STAGES-1:0] r_sync;
   always_ff @(posedge i_clk) r_sync <= i_rst ? '0 : {r_sync[STAGES-2:0], i_d};
   assign o_q = r_sync[STAGES-1];
endmodule

// File: rtl/rst_seq_multi.sv
// rst_seq_multi: multi-domain reset sequencer with lock filtering, staged release and soft reset.
//   sys_clk/sys_rst clock and sync reset; pll_locked raw lock; soft_rst_req/soft_rst_ack soft-reset handshake;
//   dom_rst/dom_rst_n per-domain resets; all_rdy all domains released; lock_lost sticky flag, lock_lost_clr clears it.
module rst_seq_multi
   import rst_seq_pkg::*;
#(
   parameter int NUM_DOM     = 4,
   parameter int SYNC_STAGES = 3,
   parameter int LOCK_FILT   = 8,
   parameter int HOLD_CYC    = 16,
   parameter int STAGE_GAP   = 8
) (
   input  logic               sys_clk,
   input  logic               sys_rst,
   input  logic               pll_locked,
   input  logic               soft_rst_req,
   output logic               soft_rst_ack,
   output logic [NUM_DOM-1:0] dom_rst,
   output logic [NUM_DOM-1:0] dom_rst_n,
   output logic               all_rdy,
   output logic               lock_lost,
   input  logic               lock_lost_clr
);
   localparam int CW = cnt_w(HOLD_CYC > STAGE_GAP ? HOLD_CYC : STAGE_GAP);
   localparam int IW = cnt_w(NUM_DOM);
   localparam int FW = cnt_w(LOCK_FILT);
   localparam logic [CW-1:0] HOLD_T = CW'(HOLD_CYC);
   localparam logic [CW-1:0] GAP_T = CW'(STAGE_GAP - 1);
   localparam logic [IW-1:0] LAST = IW'(NUM_DOM - 1);
   localparam logic [FW-1:0] FILT_T = FW'(LOCK_FILT - 1);
   localparam logic [FW-1:0] FILT_MAX = FW'(LOCK_FILT);
   // first release pattern: only domain 0 out of reset; later stages shift further zeros in
   localparam logic [NUM_DOM-1:0] REL0 = ~NUM_DOM'(1);

   logic               w_lk_s;
   logic               w_lock_ok_nxt;
   logic [FW-1:0]      r_filt;
   logic               r_lock_ok;
   logic               r_lock_lost;
   state_t             r_state;
   logic [CW-1:0]      r_cnt;
   logic [IW-1:0]      r_idx;
   logic [NUM_DOM-1:0] r_dom_rst;
   logic               r_all_rdy;
   logic               r_ack;

   sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
      .i_clk(sys_clk),
      .i_rst(sys_rst),
      .i_d  (pll_locked),
      .o_q  (w_lk_s)
   );

   // any low sample drops lock immediately; the filter only delays re-acquisition
   assign w_lock_ok_nxt = w_lk_s & (r_lock_ok | (r_filt == FILT_T));

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_filt      <= '0;
         r_lock_ok   <= 1'b0;
         r_lock_lost <= 1'b0;
      end else begin
         r_filt      <= !w_lk_s ? '0 : (r_filt == FILT_MAX) ? r_filt : r_filt + 1'b1;
         r_lock_ok   <= w_lock_ok_nxt;
         r_lock_lost <= (r_lock_ok & ~w_lock_ok_nxt) | (r_lock_lost & ~lock_lost_clr);
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_state   <= S_WAIT_LOCK;
         r_cnt     <= '0;
         r_idx     <= '0;
         r_dom_rst <= '1;
         r_all_rdy <= 1'b0;
         r_ack     <= 1'b0;
      end else if (r_state != S_WAIT_LOCK && !r_lock_ok) begin
         // lock loss overrides soft reset and any terminal count; counters are abandoned
         r_state   <= S_WAIT_LOCK;
         r_dom_rst <= '1;
         r_all_rdy <= 1'b0;
         r_ack     <= 1'b0;
      end else begin
         r_ack <= 1'b0;
         case (r_state)
            S_WAIT_LOCK: if (r_lock_ok) begin
               r_state <= S_HOLD;
               r_cnt   <= '0;
            end
            S_HOLD: if (r_cnt == HOLD_T) begin
               r_state   <= S_RELEASE;
               r_cnt     <= '0;
               r_idx     <= '0;
               r_dom_rst <= REL0;
            end else r_cnt <= r_cnt + 1'b1;
            S_RELEASE: if (r_cnt == GAP_T) begin
               r_cnt <= '0;
               if (r_idx == LAST) begin
                  r_state   <= S_RUN;
                  r_all_rdy <= 1'b1;
               end else begin
                  r_idx     <= r_idx + 1'b1;
                  r_dom_rst <= r_dom_rst << 1;
               end
            end else r_cnt <= r_cnt + 1'b1;
            S_RUN: if (soft_rst_req) begin
               r_state   <= S_SOFT;
               r_dom_rst <= '1;
               r_all_rdy <= 1'b0;
               r_ack     <= 1'b1;
            end
            S_SOFT: begin
               r_state <= S_HOLD;
               r_cnt   <= '0;
            end
            default: r_state <= S_WAIT_LOCK;
         endcase
      end
   end

   assign dom_rst      = r_dom_rst;
   assign dom_rst_n    = ~r_dom_rst;
   assign all_rdy      = r_all_rdy;
   assign soft_rst_ack = r_ack;
   assign lock_lost    = r_lock_lost;
endmodule

// File: tb/tb_rst_seq_multi.sv
// tb_rst_seq_multi: scoreboard bench for rst_seq_multi (default build plus single-domain corner build).
module tb_rst_seq_multi;
   import rst_seq_pkg::*;
   localparam int HOLD = 16;
   localparam int GAP = 8;
   localparam int ND = 4;

   typedef struct {int e; logic [ND-1:0] d; logic r; logic a;} ev_t;

   logic sys_clk = 1'b0;
   logic sys_rst = 1'b1;
   logic pll_locked = 1'b1;
   logic soft_rst_req = 1'b0;
   logic lock_lost_clr = 1'b0;
   logic rst1 = 1'b1;
   logic soft_rst_ack, all_rdy, lock_lost;
   logic [ND-1:0] dom_rst, dom_rst_n;
   logic ack1, rdy1, lost1;
   logic [0:0] dom1, dom1_n;
   int ec = 0;
   int ec1 = 0;
   int n_cmp = 0;
   int n_bad = 0;
   int g, e;
   bit mon_en = 1'b0;
   ev_t q[$];
   ev_t x;
   logic [ND+1:0] prev = '1;

   always #5 sys_clk = ~sys_clk;
   always @(posedge sys_clk) ec <= sys_rst ? 0 : ec + 1;
   always @(posedge sys_clk) ec1 <= rst1 ? 0 : ec1 + 1;

   rst_seq_multi dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .pll_locked(pll_locked),
      .soft_rst_req(soft_rst_req), .soft_rst_ack(soft_rst_ack),
      .dom_rst(dom_rst), .dom_rst_n(dom_rst_n), .all_rdy(all_rdy),
      .lock_lost(lock_lost), .lock_lost_clr(lock_lost_clr)
   );

   rst_seq_multi #(.NUM_DOM(1), .LOCK_FILT(1), .HOLD_CYC(1), .STAGE_GAP(1)) dut1 (
      .sys_clk(sys_clk), .sys_rst(rst1), .pll_locked(1'b1),
      .soft_rst_req(1'b0), .soft_rst_ack(ack1),
      .dom_rst(dom1), .dom_rst_n(dom1_n), .all_rdy(rdy1),
      .lock_lost(lost1), .lock_lost_clr(1'b0)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %0h expected %0h at t=%0t", tag, obs, exp, $time);
      end
   endtask

   // staged release expected after entering S_HOLD on edge h
   function automatic void push_release(input int h);
      logic [ND-1:0] d = '1;
      for (int i = 0; i < ND; i++) begin
         d[i] = 1'b0;
         q.push_back(ev_t'{h + HOLD + 1 + i * GAP, d, 1'b0, 1'b0});
      end
      q.push_back(ev_t'{h + HOLD + 1 + ND * GAP, {ND{1'b0}}, 1'b1, 1'b0});
   endfunction

   always @(negedge sys_clk) begin
      chk("dom_rst_n", dom_rst_n ^ dom_rst, {ND{1'b1}});
      chk("dom1_n", dom1_n ^ dom1, 1'b1);
      if (mon_en && {dom_rst, all_rdy, soft_rst_ack} != prev) begin
         if (q.size() == 0) chk("unexpected_ev", {dom_rst, all_rdy, soft_rst_ack}, prev);
         else begin
            x = q.pop_front();
            chk("ev_edge", ec, x.e);
            chk("ev_val", {dom_rst, all_rdy, soft_rst_ack}, {x.d, x.r, x.a});
         end
      end
      prev = {dom_rst, all_rdy, soft_rst_ack};
   end

   task automatic tick();
      @(negedge sys_clk);
      #1;
   endtask

   task automatic wait_ec(input int n);
      for (int i = 0; i < 400 && ec != n; i++) tick();
      if (ec != n) chk("wait_ec", ec, n);
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 200 && q.size() != 0; i++) tick();
      chk("drain", q.size(), 0);
   endtask

   task automatic wait_dom(input logic [ND-1:0] v);
      for (int i = 0; i < 200 && dom_rst != v; i++) tick();
      chk("reach_dom", dom_rst, v);
   endtask

   initial begin
      repeat (3) tick();
      chk("rst_dom", dom_rst, 4'hF);
      chk("rst_dom_n", dom_rst_n, 4'h0);
      chk("rst_rdy", all_rdy, 1'b0);
      chk("rst_ack", soft_rst_ack, 1'b0);
      chk("rst_lost", lock_lost, 1'b0);
      mon_en = 1'b1;
      push_release(12);
      sys_rst = 1'b0;
      wait_ec(10);
      chk("lock_ok_e10", dut.r_lock_ok, 1'b0);
      tick();
      chk("lock_ok_e11", dut.r_lock_ok, 1'b1);
      wait_drain();
      chk("run_rdy", all_rdy, 1'b1);
      chk("run_dom", dom_rst, 4'h0);

      g = ec + 1;
      pll_locked = 1'b0;
      q.push_back(ev_t'{g + 4, 4'hF, 1'b0, 1'b0});
      push_release(g + 12);
      tick();
      pll_locked = 1'b1;
      wait_ec(g + 2);
      chk("lost_pre", lock_lost, 1'b0);
      tick();
      chk("lost_glitch", lock_lost, 1'b1);
      tick();
      chk("glitch_dom", dom_rst, 4'hF);
      chk("glitch_rdy", all_rdy, 1'b0);
      wait_drain();
      lock_lost_clr = 1'b1;
      tick();
      lock_lost_clr = 1'b0;
      chk("lost_clr", lock_lost, 1'b0);

      e = ec + 1;
      soft_rst_req = 1'b1;
      q.push_back(ev_t'{e, 4'hF, 1'b0, 1'b1});
      q.push_back(ev_t'{e + 1, 4'hF, 1'b0, 1'b0});
      push_release(e + 1);
      tick();
      chk("ack_pulse", soft_rst_ack, 1'b1);
      repeat (3) tick();
      soft_rst_req = 1'b0;
      chk("ack_once", soft_rst_ack, 1'b0);
      wait_drain();

      g = ec + 1;
      pll_locked = 1'b0;
      q.push_back(ev_t'{g + 4, 4'hF, 1'b0, 1'b0});
      push_release(g + 12);
      tick();
      pll_locked = 1'b1;
      wait_ec(g + 2);
      lock_lost_clr = 1'b1;
      tick();
      lock_lost_clr = 1'b0;
      chk("lost_set_wins", lock_lost, 1'b1);
      wait_dom(4'b1100);
      sys_rst = 1'b1;
      q.delete();
      q.push_back(ev_t'{0, 4'hF, 1'b0, 1'b0});
      tick();
      chk("mid_rst_dom", dom_rst, 4'hF);
      chk("mid_rst_state", 32'(dut.r_state), 32'(S_WAIT_LOCK));
      chk("mid_rst_lost", lock_lost, 1'b0);
      sys_rst = 1'b0;
      push_release(12);
      wait_ec(11);
      chk("relock_e11", dut.r_lock_ok, 1'b1);
      wait_drain();

      rst1 = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("c_dom", dom1, ec1 < 7);
         chk("c_rdy", rdy1, ec1 >= 8);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
